// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: 16-deep FWFT FIFO over SRL16-style shift storage with AXI-stream handshakes.
// Every accepted write shifts the storage; the read address tracks the oldest entry.
module srl_fifo_ctrl #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [4:0]       occupied,
    output logic [4:0]       space
);
    typedef enum logic [1:0] {EMPTY, ONE, MORE, FULL} state_t;

    state_t           state_q, state_d;
    logic [3:0]       addr_q, addr_d;
    logic [4:0]       occ_q, occ_d, space_q;
    logic             ready_q, valid_q;
    logic [WIDTH-1:0] mem_q [16];
    logic             wr, rd;

    assign wr       = i_tvalid & ready_q;
    assign rd       = valid_q & o_tready;
    assign i_tready = ready_q;
    assign o_tvalid = valid_q;
    assign occupied = occ_q;
    assign space    = space_q;
    assign o_tdata  = mem_q[addr_q];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[0] <= i_tdata;
            for (int k = 1; k < 16; k++) mem_q[k] <= mem_q[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        occ_d   = (wr && !rd) ? occ_q + 5'd1 : (rd && !wr) ? occ_q - 5'd1 : occ_q;
        case (state_q)
            EMPTY: if (wr) begin
                state_d = ONE;
                addr_d  = 4'd0;
            end
            ONE: begin
                if (wr && !rd) begin
                    state_d = MORE;
                    addr_d  = 4'd1;
                end else if (rd && !wr) begin
                    state_d = EMPTY;
                end
            end
            MORE: begin
                if (wr && !rd) begin
                    addr_d  = addr_q + 4'd1;
                    state_d = (addr_q == 4'd14) ? FULL : MORE;
                end else if (rd && !wr) begin
                    addr_d  = addr_q - 4'd1;
                    state_d = (addr_q == 4'd1) ? ONE : MORE;
                end
            end
            default: if (rd) begin
                state_d = MORE;
                addr_d  = 4'd14;
            end
        endcase
        if (clear) begin
            state_d = EMPTY;
            addr_d  = 4'd0;
            occ_d   = 5'd0;
        end
    end

    // handshake flags are registered from the next state so they never depend on ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            addr_q  <= 4'd0;
            occ_q   <= 5'd0;
            space_q <= 5'd16;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            occ_q   <= occ_d;
            space_q <= 5'd16 - occ_d;
            ready_q <= (state_d != FULL);
            valid_q <= (state_d != EMPTY);
        end
    end
endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// tb_srl_fifo_ctrl: vector table, corner-case sequences and random traffic
// checked against a queue model of a 16-entry FWFT FIFO.
module tb_srl_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic [17:0] i_tdata = '0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [17:0] o_tdata;
    logic        o_tvalid;
    logic        o_tready = 1'b0;
    logic [4:0]  occupied;
    logic [4:0]  space;

    int tests = 0;
    int fails = 0;
    logic [17:0] q[$];

    typedef struct {
        logic        clr;
        logic        v;
        logic [17:0] d;
        logic        r;
        int          occ;
        logic        val;
        logic        rdy;
        logic [17:0] dat;
    } vec_t;
    vec_t tbl[9];

    srl_fifo_ctrl #(.WIDTH(18)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .occupied(occupied), .space(space)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("occupied", 32'(occupied), 32'(q.size()));
        chk("space", 32'(space), 32'(16 - q.size()));
        chk("o_tvalid", 32'(o_tvalid), 32'(q.size() > 0));
        chk("i_tready", 32'(i_tready), 32'(q.size() < 16));
        if (q.size() > 0) chk("o_tdata", 32'(o_tdata), 32'(q[0]));
    endtask

    // one clock with the given inputs; model follows handshake rules, then outputs are compared
    task automatic cyc(input logic c, input logic v, input logic [17:0] d, input logic r);
        bit wr, rd;
        clear = c; i_tvalid = v; i_tdata = d; o_tready = r;
        wr = v && (q.size() < 16);
        rd = r && (q.size() > 0);
        if (c) q.delete();
        else begin
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(d);
        end
        @(posedge clk);
        #1;
        clear = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0;
        chk_model();
    endtask

    initial begin
        int pv, pr;
        tbl[0] = '{1'b0, 1'b1, 18'h00001, 1'b0, 1, 1'b1, 1'b1, 18'h00001};
        tbl[1] = '{1'b0, 1'b1, 18'h00002, 1'b0, 2, 1'b1, 1'b1, 18'h00001};
        tbl[2] = '{1'b0, 1'b1, 18'h00003, 1'b1, 2, 1'b1, 1'b1, 18'h00002};
        tbl[3] = '{1'b0, 1'b0, 18'h3ffff, 1'b1, 1, 1'b1, 1'b1, 18'h00003};
        tbl[4] = '{1'b0, 1'b0, 18'h00000, 1'b1, 0, 1'b0, 1'b1, 18'h00000};
        tbl[5] = '{1'b0, 1'b1, 18'h2aaaa, 1'b1, 1, 1'b1, 1'b1, 18'h2aaaa};
        tbl[6] = '{1'b1, 1'b1, 18'h00006, 1'b0, 0, 1'b0, 1'b1, 18'h00000};
        tbl[7] = '{1'b0, 1'b1, 18'h15555, 1'b0, 1, 1'b1, 1'b1, 18'h15555};
        tbl[8] = '{1'b0, 1'b0, 18'h00000, 1'b1, 0, 1'b0, 1'b1, 18'h00000};

        #12;
        chk("reset o_tvalid", 32'(o_tvalid), 32'd0);
        chk("reset i_tready", 32'(i_tready), 32'd1);
        chk("reset occupied", 32'(occupied), 32'd0);
        chk("reset space", 32'(space), 32'd16);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].clr, tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d occupied", i), 32'(occupied), 32'(tbl[i].occ));
            chk($sformatf("vec%0d space", i), 32'(space), 32'(16 - tbl[i].occ));
            chk($sformatf("vec%0d o_tvalid", i), 32'(o_tvalid), 32'(tbl[i].val));
            chk($sformatf("vec%0d i_tready", i), 32'(i_tready), 32'(tbl[i].rdy));
            if (tbl[i].val) chk($sformatf("vec%0d o_tdata", i), 32'(o_tdata), 32'(tbl[i].dat));
        end

        // fill to 16, refuse the 17th, drain in order
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 18'(i), 1'b0);
        chk("full i_tready", 32'(i_tready), 32'd0);
        chk("full occupied", 32'(occupied), 32'd16);
        cyc(1'b0, 1'b1, 18'h3abcd, 1'b0);
        chk("17th occupied", 32'(occupied), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain order", 32'(o_tdata), 32'(i));
            cyc(1'b0, 1'b0, 18'h0, 1'b1);
        end
        chk("drained o_tvalid", 32'(o_tvalid), 32'd0);

        // steady state with 5 words: simultaneous read and write
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 18'(100 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk("stream data", 32'(o_tdata), 32'(100 + i));
            cyc(1'b0, 1'b1, 18'(105 + i), 1'b1);
            chk("stream occupied", 32'(occupied), 32'd5);
        end

        // full with read and write offered together: no pass-through
        cyc(1'b1, 1'b0, 18'h0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 18'(200 + i), 1'b0);
        cyc(1'b0, 1'b1, 18'h0beef, 1'b1);
        chk("full rw occupied", 32'(occupied), 32'd15);
        chk("full rw head", 32'(o_tdata), 32'd201);
        cyc(1'b0, 1'b1, 18'h0cafe, 1'b0);
        chk("refill occupied", 32'(occupied), 32'd16);

        // clear concurrently with a write
        cyc(1'b1, 1'b0, 18'h0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 18'(300 + i), 1'b0);
        cyc(1'b1, 1'b1, 18'h01234, 1'b0);
        chk("clear occupied", 32'(occupied), 32'd0);
        chk("clear o_tvalid", 32'(o_tvalid), 32'd0);
        chk("clear i_tready", 32'(i_tready), 32'd1);
        cyc(1'b0, 1'b1, 18'h00777, 1'b0);
        chk("post-clear data", 32'(o_tdata), 32'h777);
        cyc(1'b0, 1'b0, 18'h0, 1'b1);
        chk("post-clear sole", 32'(o_tvalid), 32'd0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 18'(400 + i), 1'b0);
        i_tvalid = 1'b1; o_tready = 1'b1;
        #2;
        rst = 1'b0;
        i_tvalid = 1'b0; o_tready = 1'b0;
        q.delete();
        #1;
        chk("async o_tvalid", 32'(o_tvalid), 32'd0);
        chk("async i_tready", 32'(i_tready), 32'd1);
        chk("async occupied", 32'(occupied), 32'd0);
        chk("async space", 32'(space), 32'd16);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk_model();
        cyc(1'b0, 1'b1, 18'h00042, 1'b0);
        chk("after reset data", 32'(o_tdata), 32'h42);

        // random traffic with shifting bias to hit both full and empty
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 0) begin
                pv = $urandom_range(90, 10);
                pr = $urandom_range(90, 10);
            end
            cyc($urandom_range(99) == 0, $urandom_range(99) < pv, 18'($urandom), $urandom_range(99) < pr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout at %0t: bench did not finish, expected completion", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end
endmodule
